// File: rtl/multi_timer_if.sv
// multi_timer_if
// Register bus between a host and the multi_timer block.
//   addr_i  [31:0] register address (bank in [11:8], register in [7:4])
//   data_i  [31:0] write data
//   data_o  [31:0] registered read data
//   sel_i          access strobe (read when set, write when wr_i is also set)
//   wr_i           write qualifier
// The master modport drives the request side and the slave modport returns read data.
interface multi_timer_if;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        sel_i;
  logic        wr_i;

  modport master (output addr_i, output data_i, output sel_i, output wr_i, input data_o);
  modport slave  (input addr_i, input data_i, input sel_i, input wr_i, output data_o);
endinterface

// File: rtl/multi_timer.sv
// multi_timer
// Prescaled up / up-down / one-shot counter with CHANNELS compare channels,
// each driving a PWM output, plus a sticky cause register with interrupt mask.
//   clk_i         rising-edge clock
//   rst_i         asynchronous active-high reset
//   bus           register bus (slave side of multi_timer_if)
//   irq_o         level interrupt, OR of unmasked cause bits
//   pwm_o         per-channel registered PWM outputs
// Bank 0: CTRL, COUNT, TOP, PRE, CAUSE (write-1-to-clear), MASK.
// Bank k (1..CHANNELS): OCR shadow, CFG {polarity, enable}, OCR active (read-only).
module multi_timer #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  multi_timer_if.slave        bus,
  output logic                irq_o,
  output logic [CHANNELS-1:0] pwm_o
);

  localparam logic [1:0] MODE_STOP    = 2'b00;
  localparam logic [1:0] MODE_UP      = 2'b01;
  localparam logic [1:0] MODE_UPDOWN  = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  localparam logic [3:0] REG_CTRL    = 4'd0;
  localparam logic [3:0] REG_COUNT   = 4'd1;
  localparam logic [3:0] REG_TOP     = 4'd2;
  localparam logic [3:0] REG_PRE     = 4'd3;
  localparam logic [3:0] REG_CAUSE   = 4'd4;
  localparam logic [3:0] REG_MASK    = 4'd5;

  localparam logic [3:0] REG_OCR     = 4'd0;
  localparam logic [3:0] REG_CFG     = 4'd1;
  localparam logic [3:0] REG_OCR_ACT = 4'd2;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [1:0]          ctrl_q, ctrl_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    top_q, top_d;
  logic [15:0]         pre_q, pre_d;
  logic [15:0]         presc_q, presc_d;
  logic                dirDown_q, dirDown_d;
  logic [WIDTH-1:0]    ocrShadow_q [CHANNELS];
  logic [WIDTH-1:0]    ocrShadow_d [CHANNELS];
  logic [WIDTH-1:0]    ocrActive_q [CHANNELS];
  logic [WIDTH-1:0]    ocrActive_d [CHANNELS];
  logic [CHANNELS-1:0] chEnable_q, chEnable_d;
  logic [CHANNELS-1:0] chPol_q, chPol_d;
  logic [CHANNELS:0]   cause_q, cause_d;
  logic [CHANNELS:0]   mask_q, mask_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;

  logic [3:0]          bank;
  logic [3:0]          regSel;
  logic                wrEn;
  logic                tick;
  logic                periodEvt;
  logic                oneShotDone;
  logic                tickDirDown;
  logic [WIDTH-1:0]    tickCount;
  logic [CHANNELS:0]   causeSet;
  logic [CHANNELS:0]   causeClr;
  logic [CHANNELS-1:0] shadowWr;
  logic [31:0]         readVal;
  logic                unusedBits;

  assign bank       = bus.addr_i[11:8];
  assign regSel     = bus.addr_i[7:4];
  assign wrEn       = bus.sel_i & bus.wr_i;
  assign unusedBits = ^{bus.addr_i, bus.data_i};

  // The prescaler only runs while the timer is not stopped; a tick is the
  // cycle on which it matches PRE, so PRE=0 ticks every running cycle.
  assign tick = (ctrl_q != MODE_STOP) && (presc_q == pre_q);

  // Counter advance for a tick in the current mode. This is the value the
  // counter takes unless software writes COUNT in the same cycle, and it is
  // also the "new COUNT" the compare channels match against.
  always_comb begin
    tickCount   = count_q;
    tickDirDown = dirDown_q;
    periodEvt   = 1'b0;
    oneShotDone = 1'b0;
    if (tick) begin
      case (ctrl_q)
        MODE_UP: begin
          if (count_q >= top_q) begin
            tickCount = '0;
            periodEvt = 1'b1;
          end else begin
            tickCount = count_q + CNT_ONE;
          end
        end
        MODE_UPDOWN: begin
          // Turning around at TOP steps straight down so TOP is held for
          // only one tick; TOP=0 keeps the counter parked at zero.
          if (!dirDown_q) begin
            if (count_q >= top_q) begin
              tickCount   = (top_q == '0) ? '0 : count_q - CNT_ONE;
              tickDirDown = 1'b1;
            end else begin
              tickCount = count_q + CNT_ONE;
            end
          end else begin
            tickCount = (count_q == '0) ? '0 : count_q - CNT_ONE;
          end
          if (tickCount == '0) begin
            periodEvt   = 1'b1;
            tickDirDown = 1'b0;
          end
        end
        MODE_ONESHOT: begin
          if (count_q >= top_q) begin
            tickCount   = '0;
            periodEvt   = 1'b1;
            oneShotDone = 1'b1;
          end else begin
            tickCount = count_q + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Read mux; unmapped banks and registers return zero.
  always_comb begin
    readVal = '0;
    if (bank == 4'd0) begin
      case (regSel)
        REG_CTRL:  readVal = 32'(ctrl_q);
        REG_COUNT: readVal = 32'(count_q);
        REG_TOP:   readVal = 32'(top_q);
        REG_PRE:   readVal = 32'(pre_q);
        REG_CAUSE: readVal = 32'(cause_q);
        REG_MASK:  readVal = 32'(mask_q);
        default:   readVal = '0;
      endcase
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (bank == 4'(k + 1)) begin
          case (regSel)
            REG_OCR:     readVal = 32'(ocrShadow_q[k]);
            REG_CFG:     readVal = {30'd0, chPol_q[k], chEnable_q[k]};
            REG_OCR_ACT: readVal = 32'(ocrActive_q[k]);
            default:     readVal = '0;
          endcase
        end
      end
    end
  end

  // Next-state for every register. Software writes are applied after the
  // tick update so they win, except for cause bits where a hardware set
  // beats a same-cycle clear.
  always_comb begin
    ctrl_d     = oneShotDone ? MODE_STOP : ctrl_q;
    count_d    = tickCount;
    dirDown_d  = tickDirDown;
    presc_d    = presc_q;
    top_d      = top_q;
    pre_d      = pre_q;
    mask_d     = mask_q;
    causeClr   = '0;
    chEnable_d = chEnable_q;
    chPol_d    = chPol_q;
    shadowWr   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      ocrShadow_d[k] = ocrShadow_q[k];
    end

    if (ctrl_q != MODE_STOP) begin
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end

    if (wrEn && (bank == 4'd0)) begin
      case (regSel)
        REG_CTRL: begin
          ctrl_d    = bus.data_i[1:0];
          presc_d   = 16'd0;
          dirDown_d = 1'b0;
        end
        REG_COUNT: count_d  = bus.data_i[WIDTH-1:0];
        REG_TOP:   top_d    = bus.data_i[WIDTH-1:0];
        REG_PRE:   pre_d    = bus.data_i[15:0];
        REG_CAUSE: causeClr = bus.data_i[CHANNELS:0];
        REG_MASK:  mask_d   = bus.data_i[CHANNELS:0];
        default: ;
      endcase
    end

    for (int k = 0; k < CHANNELS; k++) begin
      if (wrEn && (bank == 4'(k + 1))) begin
        case (regSel)
          REG_OCR: begin
            ocrShadow_d[k] = bus.data_i[WIDTH-1:0];
            shadowWr[k]    = 1'b1;
          end
          REG_CFG: begin
            chEnable_d[k] = bus.data_i[0];
            chPol_d[k]    = bus.data_i[1];
          end
          default: ;
        endcase
      end
    end

    // Active compare values reload at a period boundary so a PWM period is
    // never torn; while stopped there is no boundary, so writes go through.
    for (int k = 0; k < CHANNELS; k++) begin
      if (periodEvt || (shadowWr[k] && (ctrl_q == MODE_STOP))) begin
        ocrActive_d[k] = ocrShadow_d[k];
      end else begin
        ocrActive_d[k] = ocrActive_q[k];
      end
    end

    causeSet    = '0;
    causeSet[0] = periodEvt;
    for (int k = 0; k < CHANNELS; k++) begin
      causeSet[k+1] = tick && chEnable_q[k] && (tickCount == ocrActive_q[k]);
    end
    cause_d = (cause_q & ~causeClr) | causeSet;

    rdata_d = bus.sel_i ? readVal : rdata_q;

    // PWM is computed from the current count, so it trails COUNT by a cycle.
    for (int k = 0; k < CHANNELS; k++) begin
      pwm_d[k] = chEnable_q[k] ? ((count_q < ocrActive_q[k]) ^ chPol_q[k]) : chPol_q[k];
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q     <= MODE_STOP;
      count_q    <= '0;
      top_q      <= '1;
      pre_q      <= '0;
      presc_q    <= '0;
      dirDown_q  <= 1'b0;
      chEnable_q <= '0;
      chPol_q    <= '0;
      cause_q    <= '0;
      mask_q     <= '0;
      rdata_q    <= '0;
      pwm_q      <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        ocrShadow_q[k] <= '0;
        ocrActive_q[k] <= '0;
      end
    end else begin
      ctrl_q     <= ctrl_d;
      count_q    <= count_d;
      top_q      <= top_d;
      pre_q      <= pre_d;
      presc_q    <= presc_d;
      dirDown_q  <= dirDown_d;
      chEnable_q <= chEnable_d;
      chPol_q    <= chPol_d;
      cause_q    <= cause_d;
      mask_q     <= mask_d;
      rdata_q    <= rdata_d;
      pwm_q      <= pwm_d;
      for (int k = 0; k < CHANNELS; k++) begin
        ocrShadow_q[k] <= ocrShadow_d[k];
        ocrActive_q[k] <= ocrActive_d[k];
      end
    end
  end

  assign irq_o       = |(cause_q & mask_q);
  assign pwm_o       = pwm_q;
  assign bus.data_o  = rdata_q;

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer
// Directed scenario bench for multi_timer (CHANNELS=4, WIDTH=16): each task
// drives one feature through the register bus and compares against
// hand-computed values.
module tb_multi_timer;
  localparam int CH = 4;
  localparam int W  = 16;

  logic          clk;
  logic          rst;
  logic          irq;
  logic [CH-1:0] pwm;
  int            testsRun;
  int            testsFailed;

  multi_timer_if bus();

  multi_timer #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .irq_o (irq),
    .pwm_o (pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends even if something stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] gAddr(input int r);
    return 32'(r << 4);
  endfunction

  function automatic logic [31:0] chAddr(input int k, input int r);
    return 32'(((k + 1) << 8) | (r << 4));
  endfunction

  // Single bus write, captured on the posedge between two negedges.
  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr_i = a;
    bus.data_i = d;
    bus.sel_i  = 1'b1;
    bus.wr_i   = 1'b1;
    @(negedge clk);
    bus.sel_i  = 1'b0;
    bus.wr_i   = 1'b0;
  endtask

  // Single bus read; data_o is sampled at the negedge after the capturing edge.
  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.addr_i = a;
    bus.sel_i  = 1'b1;
    bus.wr_i   = 1'b0;
    @(negedge clk);
    bus.sel_i  = 1'b0;
    d = bus.data_o;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    testsRun++;
    if ({pwm, irq, bus.data_o} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got pwm=%b irq=%b data=%h expected all zero", pwm, irq, bus.data_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    busRead(gAddr(2), rd);
    testsRun++;
    if (rd !== 32'h0000_FFFF) begin
      testsFailed++;
      $display("[TB] FAIL reset_top: got %h expected 0000ffff", rd);
    end
    busRead(gAddr(0), rd);
    testsRun++;
    if (rd !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: got %h expected 0", rd);
    end
    busRead(gAddr(1), rd);
    testsRun++;
    if (rd !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_count: got %h expected 0", rd);
    end
    busRead(gAddr(4), rd);
    testsRun++;
    if (rd !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_cause: got %h expected 0", rd);
    end
  endtask

  // Up mode, TOP=9, ch0 OCR=3: high for counts 0..2 of each 10-cycle period.
  task automatic test_pwm_up();
    logic [19:0] obs;
    logic [19:0] expv;
    logic [31:0] rd;
    busWrite(gAddr(2), 32'd9);
    busWrite(gAddr(3), 32'd0);
    busWrite(chAddr(0, 0), 32'd3);
    busWrite(chAddr(0, 1), 32'd1);
    busWrite(gAddr(4), 32'h1F);
    busWrite(gAddr(0), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      obs[i-1]  = pwm[0];
      expv[i-1] = (((i - 1) % 10) < 3);
    end
    testsRun++;
    if (obs !== expv) begin
      testsFailed++;
      $display("[TB] FAIL pwm_up_pattern: got %b expected %b", obs, expv);
    end
    busRead(gAddr(4), rd);
    testsRun++;
    if (rd !== 32'd3) begin
      testsFailed++;
      $display("[TB] FAIL pwm_up_cause: got %h expected 3", rd);
    end
  endtask

  task automatic test_shadow();
    logic [31:0] rd;
    busWrite(gAddr(0), 32'd0);
    busWrite(gAddr(1), 32'd0);
    busWrite(gAddr(0), 32'd1);
    repeat (2) @(negedge clk);
    busWrite(chAddr(0, 0), 32'd7);
    busRead(chAddr(0, 2), rd);
    testsRun++;
    if (rd !== 32'd3) begin
      testsFailed++;
      $display("[TB] FAIL shadow_active_before_wrap: got %h expected 3", rd);
    end
    busRead(chAddr(0, 0), rd);
    testsRun++;
    if (rd !== 32'd7) begin
      testsFailed++;
      $display("[TB] FAIL shadow_readback: got %h expected 7", rd);
    end
    repeat (4) @(negedge clk);
    busRead(chAddr(0, 2), rd);
    testsRun++;
    if (rd !== 32'd7) begin
      testsFailed++;
      $display("[TB] FAIL shadow_active_after_wrap: got %h expected 7", rd);
    end
  endtask

  // Up-down, TOP=4, PRE=1; COUNT is streamed by holding sel_i on the COUNT address.
  task automatic test_updown();
    int          expSeq [14] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 2, 2};
    logic [31:0] obs [14];
    logic [31:0] c1, c2, c3;
    int          badIdx;
    busWrite(gAddr(0), 32'd0);
    busWrite(gAddr(1), 32'd0);
    busWrite(gAddr(2), 32'd4);
    busWrite(gAddr(3), 32'd1);
    busWrite(gAddr(4), 32'h1F);
    busWrite(gAddr(0), 32'd2);
    bus.addr_i = gAddr(1);
    bus.sel_i  = 1'b1;
    bus.wr_i   = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      obs[i] = bus.data_o;
    end
    bus.addr_i = gAddr(4);
    @(negedge clk);
    c1 = bus.data_o;
    @(negedge clk);
    c2 = bus.data_o;
    @(negedge clk);
    c3 = bus.data_o;
    bus.sel_i = 1'b0;
    badIdx = -1;
    for (int i = 0; i < 14; i++) begin
      if ((badIdx < 0) && (obs[i] !== 32'(expSeq[i]))) badIdx = i;
    end
    testsRun++;
    if (badIdx >= 0) begin
      testsFailed++;
      $display("[TB] FAIL updown_sequence: sample %0d got %h expected %0d", badIdx, obs[badIdx], expSeq[badIdx]);
    end
    testsRun++;
    if ({c1, c2} !== 64'd0) begin
      testsFailed++;
      $display("[TB] FAIL updown_no_early_period: got %h %h expected 0 0", c1, c2);
    end
    testsRun++;
    if (c3 !== 32'd1) begin
      testsFailed++;
      $display("[TB] FAIL updown_period_at_zero: got %h expected 1", c3);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    busWrite(gAddr(0), 32'd0);
    busWrite(gAddr(1), 32'd0);
    busWrite(gAddr(2), 32'd5);
    busWrite(gAddr(3), 32'd0);
    busWrite(gAddr(5), 32'd0);
    busWrite(gAddr(4), 32'h1F);
    busWrite(gAddr(0), 32'd3);
    repeat (12) @(negedge clk);
    busRead(gAddr(1), rd);
    testsRun++;
    if (rd !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL oneshot_count: got %h expected 0", rd);
    end
    busRead(gAddr(0), rd);
    testsRun++;
    if (rd !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL oneshot_ctrl: got %h expected 0", rd);
    end
    busRead(gAddr(4), rd);
    testsRun++;
    if (rd !== 32'd1) begin
      testsFailed++;
      $display("[TB] FAIL oneshot_cause: got %h expected 1", rd);
    end
    testsRun++;
    if (irq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL oneshot_irq_masked: got %b expected 0", irq);
    end
    busWrite(gAddr(5), 32'd1);
    testsRun++;
    if (irq !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL oneshot_irq_unmasked: got %b expected 1", irq);
    end
    busWrite(gAddr(4), 32'd1);
    testsRun++;
    if (irq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL oneshot_irq_cleared: got %b expected 0", irq);
    end
  endtask

  // TOP=3, PRE=0: period events on every 4th edge after start; the first
  // clear lands on a period edge, the second one between period edges.
  task automatic test_w1c_collision();
    logic [31:0] rd;
    busWrite(gAddr(0), 32'd0);
    busWrite(gAddr(1), 32'd0);
    busWrite(gAddr(2), 32'd3);
    busWrite(gAddr(4), 32'h1F);
    busWrite(gAddr(0), 32'd1);
    repeat (2) @(negedge clk);
    busWrite(gAddr(4), 32'd1);
    busRead(gAddr(4), rd);
    testsRun++;
    if (rd[0] !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL w1c_set_wins: got bit0=%b expected 1", rd[0]);
    end
    repeat (1) @(negedge clk);
    busWrite(gAddr(4), 32'd1);
    busRead(gAddr(4), rd);
    testsRun++;
    if (rd[0] !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL w1c_clear: got bit0=%b expected 0", rd[0]);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] rd;
    busWrite(gAddr(0), 32'd0);
    busWrite(gAddr(2), 32'd0);
    busWrite(chAddr(0, 0), 32'd0);
    busWrite(chAddr(1, 0), 32'd5);
    busWrite(chAddr(1, 1), 32'd1);
    busWrite(chAddr(2, 1), 32'd2);
    busWrite(gAddr(4), 32'h1F);
    busWrite(gAddr(0), 32'd1);
    repeat (3) @(negedge clk);
    testsRun++;
    if (pwm !== 4'b0110) begin
      testsFailed++;
      $display("[TB] FAIL boundary_pwm_levels: got %b expected 0110", pwm);
    end
    busRead(gAddr(1), rd);
    testsRun++;
    if (rd !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL boundary_top0_count: got %h expected 0", rd);
    end
    busWrite(gAddr(4), 32'd3);
    busRead(gAddr(4), rd);
    testsRun++;
    if (rd !== 32'd3) begin
      testsFailed++;
      $display("[TB] FAIL boundary_top0_cause: got %h expected 3", rd);
    end
  endtask

  task automatic test_count_write();
    logic [31:0] rd;
    busWrite(gAddr(0), 32'd0);
    busWrite(gAddr(2), 32'h0000_FFFF);
    busWrite(gAddr(0), 32'd1);
    busWrite(gAddr(1), 32'h0001_2345);
    busRead(gAddr(1), rd);
    testsRun++;
    if (rd !== 32'h0000_2346) begin
      testsFailed++;
      $display("[TB] FAIL count_write_precedence: got %h expected 00002346", rd);
    end
    busWrite(gAddr(0), 32'd0);
    busRead(gAddr(6), rd);
    testsRun++;
    if (rd !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL unmapped_global_reg: got %h expected 0", rd);
    end
    busRead(chAddr(4, 0), rd);
    testsRun++;
    if (rd !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL unmapped_bank: got %h expected 0", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    busWrite(gAddr(0), 32'd0);
    busWrite(gAddr(1), 32'd0);
    busWrite(gAddr(2), 32'd9);
    busWrite(gAddr(5), 32'h1F);
    busWrite(gAddr(4), 32'h1F);
    busWrite(chAddr(0, 0), 32'd7);
    busWrite(gAddr(0), 32'd1);
    bus.addr_i = gAddr(2);
    bus.sel_i  = 1'b1;
    bus.wr_i   = 1'b0;
    repeat (12) @(negedge clk);
    bus.sel_i = 1'b0;
    testsRun++;
    if ({pwm[0], irq, bus.data_o} !== {1'b1, 1'b1, 32'd9}) begin
      testsFailed++;
      $display("[TB] FAIL midreset_precondition: got pwm0=%b irq=%b data=%h expected 1 1 9", pwm[0], irq, bus.data_o);
    end
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if ({pwm, irq, bus.data_o} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_async_outputs: got pwm=%b irq=%b data=%h expected all zero", pwm, irq, bus.data_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    busRead(gAddr(0), rd);
    testsRun++;
    if (rd !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_ctrl: got %h expected 0", rd);
    end
    busRead(gAddr(2), rd);
    testsRun++;
    if (rd !== 32'h0000_FFFF) begin
      testsFailed++;
      $display("[TB] FAIL midreset_top: got %h expected 0000ffff", rd);
    end
    busRead(gAddr(4), rd);
    testsRun++;
    if (rd !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_cause: got %h expected 0", rd);
    end
    busRead(gAddr(5), rd);
    testsRun++;
    if (rd !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_mask: got %h expected 0", rd);
    end
    busRead(chAddr(0, 2), rd);
    testsRun++;
    if (rd !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_ocr_active: got %h expected 0", rd);
    end
    busRead(chAddr(1, 1), rd);
    testsRun++;
    if (rd !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_cfg: got %h expected 0", rd);
    end
    testsRun++;
    if ({pwm, irq} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_outputs_after: got pwm=%b irq=%b expected 0 0", pwm, irq);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    bus.addr_i  = '0;
    bus.data_i  = '0;
    bus.sel_i   = 1'b0;
    bus.wr_i    = 1'b0;
    test_reset();
    test_pwm_up();
    test_shadow();
    test_updown();
    test_oneshot();
    test_w1c_collision();
    test_boundaries();
    test_count_write();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
